// File: rtl/pixel_rowcol_arbiter.sv
// rtl/pixel_rowcol_arbiter.sv - two-level (row, then column) round-robin pixel request arbiter
// Grants are held until ack_i; each row is snapshotted on entry so a pass is fair.
module pixel_rowcol_arbiter #(
   parameter int Lvl_ROWS    = 4,
   parameter int Lvl_COLS    = 4,
   parameter int Lvl_ROW_ADD = $clog2(Lvl_ROWS),
   parameter int Lvl_COL_ADD = $clog2(Lvl_COLS)
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic                               enable_i,
   input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  req_i,
   input  logic                               ack_i,
   output logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  gnt_o,
   output logic [Lvl_ROW_ADD-1:0]             x_add_o,
   output logic [Lvl_COL_ADD-1:0]             y_add_o,
   output logic                               active_o,
   output logic                               req_o,
   output logic                               grp_release_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ROW_ARB   = 2'd1,
      COL_GRANT = 2'd2,
      RELEASE   = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [Lvl_ROW_ADD:0]   r_row_ptr;
   logic [Lvl_ROW_ADD:0]   w_row_ptr_nxt;
   logic [Lvl_COLS-1:0]    r_col_mask;
   logic [Lvl_COLS-1:0]    w_col_mask_nxt;
   logic                   r_gnt_valid;
   logic                   w_gnt_valid_nxt;
   logic [Lvl_ROW_ADD-1:0] r_x_add;
   logic [Lvl_ROW_ADD-1:0] w_x_add_nxt;
   logic [Lvl_COL_ADD-1:0] r_y_add;
   logic [Lvl_COL_ADD-1:0] w_y_add_nxt;

   logic                   w_row_hit;
   logic [Lvl_ROW_ADD-1:0] w_row_idx;
   logic [Lvl_COLS-1:0]    w_row_req;
   logic [Lvl_COL_ADD-1:0] w_first_col;
   logic [Lvl_COLS-1:0]    w_cur_cand;
   logic                   w_nxt_hit;
   logic [Lvl_COL_ADD-1:0] w_nxt_col;
   logic                   w_active;

   assign req_o = |req_i;

   // Lowest requesting row at or after the pass pointer
   always_comb begin
      w_row_hit = 1'b0;
      w_row_idx = '0;
      for (int r = Lvl_ROWS - 1; r >= 0; r--) begin
         if ((r >= int'(r_row_ptr)) && (|req_i[r])) begin
            w_row_hit = 1'b1;
            w_row_idx = Lvl_ROW_ADD'(r);
         end
      end
   end

   assign w_row_req = req_i[w_row_idx];

   always_comb begin
      w_first_col = '0;
      for (int c = Lvl_COLS - 1; c >= 0; c--) begin
         if (w_row_req[c]) begin
            w_first_col = Lvl_COL_ADD'(c);
         end
      end
   end

   // Next column must be in the snapshot and still requesting
   assign w_cur_cand = r_col_mask & req_i[r_x_add];

   always_comb begin
      w_nxt_hit = 1'b0;
      w_nxt_col = '0;
      for (int c = Lvl_COLS - 1; c >= 0; c--) begin
         if (w_cur_cand[c] && (c > int'(r_y_add))) begin
            w_nxt_hit = 1'b1;
            w_nxt_col = Lvl_COL_ADD'(c);
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_row_ptr_nxt   = r_row_ptr;
      w_col_mask_nxt  = r_col_mask;
      w_gnt_valid_nxt = r_gnt_valid;
      w_x_add_nxt     = r_x_add;
      w_y_add_nxt     = r_y_add;
      case (r_state)
         IDLE: begin
            w_row_ptr_nxt   = '0;
            w_gnt_valid_nxt = 1'b0;
            if (enable_i && req_o) begin
               w_state_nxt = ROW_ARB;
            end
         end
         ROW_ARB: begin
            if (w_row_hit) begin
               w_x_add_nxt     = w_row_idx;
               w_col_mask_nxt  = w_row_req;
               w_y_add_nxt     = w_first_col;
               w_gnt_valid_nxt = 1'b1;
               w_state_nxt     = COL_GRANT;
            end else begin
               w_state_nxt = RELEASE;
            end
         end
         COL_GRANT: begin
            if (ack_i) begin
               if (w_nxt_hit) begin
                  w_y_add_nxt = w_nxt_col;
               end else if (int'(r_x_add) == Lvl_ROWS - 1) begin
                  w_gnt_valid_nxt = 1'b0;
                  w_state_nxt     = RELEASE;
               end else begin
                  w_gnt_valid_nxt = 1'b0;
                  w_row_ptr_nxt   = (Lvl_ROW_ADD+1)'(r_x_add) + (Lvl_ROW_ADD+1)'(1);
                  w_state_nxt     = ROW_ARB;
               end
            end
         end
         RELEASE: begin
            w_row_ptr_nxt = '0;
            w_state_nxt   = (enable_i && req_o) ? ROW_ARB : IDLE;
         end
         default: begin
            w_state_nxt     = IDLE;
            w_row_ptr_nxt   = '0;
            w_gnt_valid_nxt = 1'b0;
         end
      endcase
      // Disable abandons the pass without a release pulse
      if (!enable_i) begin
         w_state_nxt     = IDLE;
         w_row_ptr_nxt   = '0;
         w_gnt_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_row_ptr   <= '0;
         r_col_mask  <= '0;
         r_gnt_valid <= 1'b0;
         r_x_add     <= '0;
         r_y_add     <= '0;
      end else begin
         r_row_ptr   <= w_row_ptr_nxt;
         r_col_mask  <= w_col_mask_nxt;
         r_gnt_valid <= w_gnt_valid_nxt;
         r_x_add     <= w_x_add_nxt;
         r_y_add     <= w_y_add_nxt;
      end
   end

   assign w_active      = r_gnt_valid && (r_state == COL_GRANT);
   assign active_o      = w_active;
   assign grp_release_o = (r_state == RELEASE);
   assign x_add_o       = w_active ? r_x_add : '0;
   assign y_add_o       = w_active ? r_y_add : '0;

   always_comb begin
      gnt_o = '0;
      if (w_active) begin
         gnt_o[r_x_add][r_y_add] = 1'b1;
      end
   end

endmodule

// File: tb/tb_pixel_rowcol_arbiter.sv
// tb/tb_pixel_rowcol_arbiter.sv - directed bench for pixel_rowcol_arbiter
module tb_pixel_rowcol_arbiter;

   logic             clk = 1'b0;
   logic             reset_i;
   logic             enable_i;
   logic [3:0][3:0]  req_i;
   logic             ack_i;
   logic [3:0][3:0]  gnt_o;
   logic [1:0]       x_add_o;
   logic [1:0]       y_add_o;
   logic             active_o;
   logic             req_o;
   logic             grp_release_o;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [21:0] ST_IDLE = 22'd0;
   localparam logic [21:0] ST_REL  = 22'd1;

   wire [21:0] w_obs = {gnt_o, x_add_o, y_add_o, active_o, grp_release_o};

   always #5 clk = ~clk;

   pixel_rowcol_arbiter dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .enable_i     (enable_i),
      .req_i        (req_i),
      .ack_i        (ack_i),
      .gnt_o        (gnt_o),
      .x_add_o      (x_add_o),
      .y_add_o      (y_add_o),
      .active_o     (active_o),
      .req_o        (req_o),
      .grp_release_o(grp_release_o)
   );

   function automatic logic [21:0] g(input int x, input int y);
      logic [15:0] oh;
      oh = '0;
      oh[x*4+y] = 1'b1;
      return {oh, 2'(x), 2'(y), 1'b1, 1'b0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; enable_i = 1'b0; ack_i = 1'b0; req_i = '1;
      #12;
      if (w_obs !== ST_IDLE) $display("FAIL reset_outputs obs=%h exp=%h", w_obs, ST_IDLE); else n_pass++;
      n_total++;
      if (req_o !== 1'b1) $display("FAIL reset_req_o obs=%b exp=1", req_o); else n_pass++;
      n_total++;
      step(); reset_i = 1'b0;
      step(); step(); step();
      if (w_obs !== ST_IDLE) $display("FAIL disabled_idle obs=%h exp=%h", w_obs, ST_IDLE); else n_pass++;
      n_total++;
      req_i = '0; #1;
      if (req_o !== 1'b0) $display("FAIL req_o_low obs=%b exp=0", req_o); else n_pass++;
      n_total++;
   endtask

   task automatic test_single();
      req_i = '0; req_i[1][2] = 1'b1; enable_i = 1'b1;
      step();
      if (w_obs !== ST_IDLE) $display("FAIL single_row_arb obs=%h exp=%h", w_obs, ST_IDLE); else n_pass++;
      n_total++;
      step();
      if (w_obs !== g(1, 2)) $display("FAIL single_grant obs=%h exp=%h", w_obs, g(1, 2)); else n_pass++;
      n_total++;
      for (int i = 0; i < 5; i++) begin
         step();
         if (w_obs !== g(1, 2)) $display("FAIL single_hold%0d obs=%h exp=%h", i, w_obs, g(1, 2)); else n_pass++;
         n_total++;
      end
      ack_i = 1'b1;
      step();
      ack_i = 1'b0; req_i = '0;
      if (w_obs !== ST_IDLE) $display("FAIL single_after_ack obs=%h exp=%h", w_obs, ST_IDLE); else n_pass++;
      n_total++;
      step();
      if (w_obs !== ST_REL) $display("FAIL single_release obs=%h exp=%h", w_obs, ST_REL); else n_pass++;
      n_total++;
      step();
      if (w_obs !== ST_IDLE) $display("FAIL single_pulse_width obs=%h exp=%h", w_obs, ST_IDLE); else n_pass++;
      n_total++;
   endtask

   task automatic test_back_to_back();
      req_i = '0; req_i[2][0] = 1'b1; req_i[2][1] = 1'b1; req_i[2][3] = 1'b1; ack_i = 1'b1;
      step();
      step();
      if (w_obs !== g(2, 0)) $display("FAIL b2b_y0 obs=%h exp=%h", w_obs, g(2, 0)); else n_pass++;
      n_total++;
      step();
      if (w_obs !== g(2, 1)) $display("FAIL b2b_y1 obs=%h exp=%h", w_obs, g(2, 1)); else n_pass++;
      n_total++;
      step();
      if (w_obs !== g(2, 3)) $display("FAIL b2b_y3 obs=%h exp=%h", w_obs, g(2, 3)); else n_pass++;
      n_total++;
      step();
      if (w_obs !== ST_IDLE) $display("FAIL b2b_row_arb obs=%h exp=%h", w_obs, ST_IDLE); else n_pass++;
      n_total++;
      step();
      if (w_obs !== ST_REL) $display("FAIL b2b_release obs=%h exp=%h", w_obs, ST_REL); else n_pass++;
      n_total++;
      req_i = '0; ack_i = 1'b0;
      step();
      if (w_obs !== ST_IDLE) $display("FAIL b2b_idle obs=%h exp=%h", w_obs, ST_IDLE); else n_pass++;
      n_total++;
   endtask

   task automatic test_snapshot();
      req_i = '0; req_i[0][0] = 1'b1; req_i[0][1] = 1'b1;
      step(); step();
      if (w_obs !== g(0, 0)) $display("FAIL snap_g00 obs=%h exp=%h", w_obs, g(0, 0)); else n_pass++;
      n_total++;
      req_i[0][3] = 1'b1; req_i[3][0] = 1'b1;
      step();
      ack_i = 1'b1;
      step();
      ack_i = 1'b0; req_i[0][0] = 1'b0;
      if (w_obs !== g(0, 1)) $display("FAIL snap_g01 obs=%h exp=%h", w_obs, g(0, 1)); else n_pass++;
      n_total++;
      ack_i = 1'b1;
      step();
      ack_i = 1'b0; req_i[0][1] = 1'b0;
      step();
      if (w_obs !== g(3, 0)) $display("FAIL snap_g30 obs=%h exp=%h", w_obs, g(3, 0)); else n_pass++;
      n_total++;
      ack_i = 1'b1;
      step();
      ack_i = 1'b0; req_i[3][0] = 1'b0;
      if (w_obs !== ST_REL) $display("FAIL snap_release obs=%h exp=%h", w_obs, ST_REL); else n_pass++;
      n_total++;
      step();
      step();
      if (w_obs !== g(0, 3)) $display("FAIL snap_next_pass_g03 obs=%h exp=%h", w_obs, g(0, 3)); else n_pass++;
      n_total++;
      ack_i = 1'b1;
      step();
      ack_i = 1'b0; req_i = '0;
      step(); step();
   endtask

   task automatic test_drop_skip();
      req_i = '0; req_i[1][0] = 1'b1; req_i[1][1] = 1'b1; req_i[1][2] = 1'b1;
      step(); step();
      if (w_obs !== g(1, 0)) $display("FAIL drop_g10 obs=%h exp=%h", w_obs, g(1, 0)); else n_pass++;
      n_total++;
      req_i[1][0] = 1'b0;
      step();
      if (w_obs !== g(1, 0)) $display("FAIL drop_held obs=%h exp=%h", w_obs, g(1, 0)); else n_pass++;
      n_total++;
      req_i[1][1] = 1'b0;
      step();
      ack_i = 1'b1;
      step();
      ack_i = 1'b0;
      if (w_obs !== g(1, 2)) $display("FAIL drop_skip_g12 obs=%h exp=%h", w_obs, g(1, 2)); else n_pass++;
      n_total++;
      ack_i = 1'b1;
      step();
      ack_i = 1'b0; req_i = '0;
      step();
      if (w_obs !== ST_REL) $display("FAIL drop_release obs=%h exp=%h", w_obs, ST_REL); else n_pass++;
      n_total++;
      step();
   endtask

   task automatic test_disable();
      req_i = '0; req_i[3][3] = 1'b1;
      step(); step();
      if (w_obs !== g(3, 3)) $display("FAIL dis_g33 obs=%h exp=%h", w_obs, g(3, 3)); else n_pass++;
      n_total++;
      enable_i = 1'b0;
      step();
      if (w_obs !== ST_IDLE) $display("FAIL dis_abandon obs=%h exp=%h", w_obs, ST_IDLE); else n_pass++;
      n_total++;
      step();
      if (w_obs !== ST_IDLE) $display("FAIL dis_no_release obs=%h exp=%h", w_obs, ST_IDLE); else n_pass++;
      n_total++;
      req_i[0][1] = 1'b1; enable_i = 1'b1;
      step(); step();
      if (w_obs !== g(0, 1)) $display("FAIL dis_reenable_g01 obs=%h exp=%h", w_obs, g(0, 1)); else n_pass++;
      n_total++;
   endtask

   task automatic test_reset_mid_grant();
      #3 reset_i = 1'b1;
      #1;
      if (w_obs !== ST_IDLE) $display("FAIL async_reset obs=%h exp=%h", w_obs, ST_IDLE); else n_pass++;
      n_total++;
      step();
      reset_i = 1'b0; req_i = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_snapshot();
      test_drop_skip();
      test_disable();
      test_reset_mid_grant();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
